btn_debounce_events: RTL and testbench

- Multi-channel, parametrised button debouncer with per-channel press/release event capture.
- Sits between raw board push-buttons and an HLS-generated accelerator, behind a start_port/done_port call interface.
- Each call returns the debounced levels, the sticky press events, the sticky release events and an overrun flag. The press, release and overrun state clears when read.

---
 rtl/btn_debounce_events.sv | 147 ++++++++++++++
 tb/tb_btn_debounce_events.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_events.sv
// Multi-channel button debouncer with sticky press/release event capture behind a
// start_port/done_port call interface. Define BTN_DEBOUNCE_AUTOREPEAT_EN for held-key auto-repeat.
module btn_debounce_events #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CLOCKS = 4096,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 1000000,
    parameter int REPEAT_PERIOD   = 250000,
    parameter int RPT_W           = 24
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start_port,
    output logic            done_port,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] out1,
    output logic [N_CH-1:0] out2,
    output logic [N_CH-1:0] out3,
    output logic            out4
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CLOCKS - 1);

    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  sync2;
    logic [N_CH-1:0]  cand;
    logic [N_CH-1:0]  cand_d;
    logic [CNT_W-1:0] cnt   [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  stable;
    logic [N_CH-1:0]  stable_d;
    logic [N_CH-1:0]  rise_pend;
    logic [N_CH-1:0]  fall_pend;
    logic             ovr;

    logic [N_CH-1:0]  rise_now;
    logic [N_CH-1:0]  fall_now;
    logic [N_CH-1:0]  rise_ev;
    logic [N_CH-1:0]  rpt_fire;
    logic             ovr_hit;

    // Per-channel debounce: any sample differing from the candidate restarts the count.
    always_comb begin
        cand_d   = cand;
        stable_d = stable;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt[i];
            if (sync2[i] != cand[i]) begin
                cand_d[i] = sync2[i];
                cnt_d[i]  = '0;
            end else if (cnt[i] == CNT_MAX) begin
                stable_d[i] = cand[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt[i] + 1'b1;
            end
        end
    end

    assign rise_now = stable_d & ~stable;
    assign fall_now = ~stable_d & stable;
    assign rise_ev  = rise_now | rpt_fire;
    assign ovr_hit  = (|(rise_ev & rise_pend)) | (|(fall_now & fall_pend));

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [RPT_W-1:0] RPT_DLY_MAX = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PER_MAX = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt   [N_CH];
    logic [RPT_W-1:0] rpt_cnt_d [N_CH];
    logic [N_CH-1:0]  rpt_phase;
    logic [N_CH-1:0]  rpt_phase_d;

    // rpt_phase selects the initial delay (0) or the steady repeat period (1).
    always_comb begin
        rpt_fire    = '0;
        rpt_phase_d = rpt_phase;
        for (int i = 0; i < N_CH; i++) begin
            rpt_cnt_d[i] = rpt_cnt[i];
            if (!stable[i]) begin
                rpt_cnt_d[i]   = '0;
                rpt_phase_d[i] = 1'b0;
            end else if (rpt_cnt[i] == (rpt_phase[i] ? RPT_PER_MAX : RPT_DLY_MAX)) begin
                rpt_fire[i]    = stable_d[i];
                rpt_cnt_d[i]   = '0;
                rpt_phase_d[i] = 1'b1;
            end else begin
                rpt_cnt_d[i] = rpt_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rpt_phase <= '0;
            for (int i = 0; i < N_CH; i++) rpt_cnt[i] <= '0;
        end else begin
            rpt_phase <= rpt_phase_d;
            for (int i = 0; i < N_CH; i++) rpt_cnt[i] <= rpt_cnt_d[i];
        end
    end
`else
    logic [RPT_W-1:0] unused_rpt_cfg;
    assign unused_rpt_cfg = RPT_W'(REPEAT_DELAY) ^ RPT_W'(REPEAT_PERIOD);
    assign rpt_fire       = '0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1     <= '0;
            sync2     <= '0;
            cand      <= '0;
            stable    <= '0;
            rise_pend <= '0;
            fall_pend <= '0;
            ovr       <= 1'b0;
            done_port <= 1'b0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out4      <= 1'b0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            sync1     <= btn;
            sync2     <= sync1;
            cand      <= cand_d;
            stable    <= stable_d;
            done_port <= start_port;
            for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_d[i];
            // A read hands out the old pending state and re-arms with this edge's events.
            if (start_port) begin
                out1      <= stable;
                out2      <= rise_pend;
                out3      <= fall_pend;
                out4      <= ovr;
                rise_pend <= rise_ev;
                fall_pend <= fall_now;
                ovr       <= 1'b0;
            end else begin
                rise_pend <= rise_pend | rise_ev;
                fall_pend <= fall_pend | fall_now;
                if (ovr_hit) ovr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce_events.sv
// Directed bench for btn_debounce_events (4 channels, 4-clock debounce): latency,
// glitch rejection, read-clear on the event edge, overrun and reset in mid-flight.
module tb_btn_debounce_events;

    logic       clock;
    logic       reset;
    logic       start_port;
    logic       done_port;
    logic [3:0] btn;
    logic [3:0] out1;
    logic [3:0] out2;
    logic [3:0] out3;
    logic       out4;

    int tests_run = 0;
    int tests_failed = 0;

    btn_debounce_events #(
        .N_CH(4),
        .DEBOUNCE_CLOCKS(4),
        .CNT_W(16),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5),
        .RPT_W(24)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start_port(start_port),
        .done_port(done_port),
        .btn(btn),
        .out1(out1),
        .out2(out2),
        .out3(out3),
        .out4(out4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One call edge; start_port is left at 'hold' afterwards for back-to-back calls.
    task automatic call_step(input string tag, input logic hold, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3, input logic e4);
        start_port = 1'b1;
        tick(1);
        start_port = hold;
        chk({tag, "_done"}, {3'b0, done_port}, 4'b0001);
        chk({tag, "_out1"}, out1, e1);
        chk({tag, "_out2"}, out2, e2);
        chk({tag, "_out3"}, out3, e3);
        chk({tag, "_out4"}, {3'b0, out4}, {3'b0, e4});
    endtask

    task automatic call_end(input string tag);
        tick(1);
        chk({tag, "_done_low"}, {3'b0, done_port}, 4'b0000);
    endtask

    initial begin
        reset      = 1'b0;
        start_port = 1'b0;
        btn        = 4'b0000;
        tick(3);
        chk("rst_done", {3'b0, done_port}, 4'b0000);
        chk("rst_out1", out1, 4'b0000);
        chk("rst_out2", out2, 4'b0000);
        chk("rst_out3", out3, 4'b0000);
        chk("rst_out4", {3'b0, out4}, 4'b0000);
        reset = 1'b1;
        tick(2);

        // Basic press: edge k first samples 0001; stable rises at k+6.
        btn = 4'b0001;
        tick(6);
        call_step("press_k6", 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        call_step("press_k7", 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
        call_end("press");
        call_step("press_clr", 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        call_end("press_clr");

        // Bounce on ch1: 3-clock runs never reach acceptance.
        for (int i = 0; i < 40; i++) begin
            btn[1] = ((i / 3) % 2) == 0;
            tick(1);
        end
        btn[1] = 1'b0;
        tick(10);
        call_step("bounce", 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        call_end("bounce");

        // Overrun on ch3: press, release, press with no call in between.
        btn = 4'b1001;
        tick(10);
        btn = 4'b0001;
        tick(10);
        btn = 4'b1001;
        tick(10);
        call_step("ovr_1", 1'b0, 4'b1001, 4'b1000, 4'b1000, 1'b1);
        call_end("ovr_1");
        call_step("ovr_2", 1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b0);
        call_end("ovr_2");

        // Pulse length boundary on ch2: 4 clocks rejected, 5 clocks accepted.
        btn = 4'b1101;
        tick(4);
        btn = 4'b1001;
        tick(10);
        call_step("pulse4", 1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b0);
        call_end("pulse4");
        btn = 4'b1101;
        tick(5);
        btn = 4'b1001;
        tick(10);
        call_step("pulse5", 1'b0, 4'b1001, 4'b0100, 4'b0100, 1'b0);
        call_end("pulse5");

        // Call on the exact edge stable[2] rises, then two more back-to-back calls.
        btn = 4'b1101;
        tick(6);
        call_step("same_1", 1'b1, 4'b1001, 4'b0000, 4'b0000, 1'b0);
        call_step("same_2", 1'b1, 4'b1101, 4'b0100, 4'b0000, 1'b0);
        call_step("same_3", 1'b0, 4'b1101, 4'b0000, 4'b0000, 1'b0);
        call_end("same");

        btn = 4'b0000;
        tick(10);
        call_step("release", 1'b0, 4'b0000, 4'b0000, 4'b1101, 1'b0);
        call_end("release");

        // Reset at k+3 during a pending press and an in-flight call.
        btn = 4'b0001;
        tick(3);
        reset      = 1'b0;
        start_port = 1'b1;
        tick(1);
        reset      = 1'b1;
        start_port = 1'b0;
        chk("rstmid_done", {3'b0, done_port}, 4'b0000);
        chk("rstmid_out1", out1, 4'b0000);
        chk("rstmid_out2", out2, 4'b0000);
        chk("rstmid_out3", out3, 4'b0000);
        chk("rstmid_out4", {3'b0, out4}, 4'b0000);
        tick(6);
        call_step("rst_r7", 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        call_step("rst_r8", 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
        call_end("rst_after");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        tests_failed++;
        $display("FAIL timeout: observed running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
